// File: rtl/pixel_coord_streamer.sv
// Streams one (hcount, vcount) pair per pixel, row-major, first valid 1 cycle after start;
// each channel holds its beat until its own handshake, pair advances once both are taken. Macro: PIXEL_COORD_STREAMER_CONTINUOUS_EN.
module pixel_coord_streamer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 360
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  output logic [10:0] hcount_axis_tdata,
  output logic        hcount_axis_tvalid,
  input  logic        hcount_axis_tready,
  output logic [9:0]  vcount_axis_tdata,
  output logic        vcount_axis_tvalid,
  input  logic        vcount_axis_tready,
  output logic        eol,
  output logic        eof,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

  state_t      state;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_vld;
  logic        v_vld;
  logic        h_taken;
  logic        v_taken;
  logic        busy_q;
  logic        done_q;

  logic h_hs;
  logic v_hs;
  logic pair_done;
  logic last_h;
  logic last_v;

  assign h_hs      = h_vld & hcount_axis_tready;
  assign v_hs      = v_vld & vcount_axis_tready;
  // A pair completes when each channel has either already handshaked or does so now.
  assign pair_done = (state == RUN) & (h_taken | h_hs) & (v_taken | v_hs);
  assign last_h    = (h_cnt == H_LAST);
  assign last_v    = (v_cnt == V_LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      h_cnt   <= '0;
      v_cnt   <= '0;
      h_vld   <= 1'b0;
      v_vld   <= 1'b0;
      h_taken <= 1'b0;
      v_taken <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            h_cnt   <= '0;
            v_cnt   <= '0;
            h_vld   <= 1'b1;
            v_vld   <= 1'b1;
            h_taken <= 1'b0;
            v_taken <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (pair_done) begin
            h_taken <= 1'b0;
            v_taken <= 1'b0;
            if (last_h && last_v) begin
              done_q <= 1'b1;
              h_cnt  <= '0;
              v_cnt  <= '0;
`ifdef PIXEL_COORD_STREAMER_CONTINUOUS_EN
              h_vld  <= 1'b1;
              v_vld  <= 1'b1;
`else
              state  <= IDLE;
              h_vld  <= 1'b0;
              v_vld  <= 1'b0;
              busy_q <= 1'b0;
`endif
            end else begin
              if (last_h) begin
                h_cnt <= '0;
                v_cnt <= v_cnt + 10'd1;
              end else begin
                h_cnt <= h_cnt + 11'd1;
              end
              h_vld <= 1'b1;
              v_vld <= 1'b1;
            end
          end else begin
            // One channel handshaked alone: park it until the other catches up.
            if (h_hs) begin
              h_vld   <= 1'b0;
              h_taken <= 1'b1;
            end
            if (v_hs) begin
              v_vld   <= 1'b0;
              v_taken <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hcount_axis_tdata  = h_cnt;
  assign vcount_axis_tdata  = v_cnt;
  assign hcount_axis_tvalid = h_vld;
  assign vcount_axis_tvalid = v_vld;
  assign busy               = busy_q;
  assign frame_done         = done_q;
  assign eol                = busy_q & last_h;
  assign eof                = busy_q & last_h & last_v;

endmodule

// File: tb/tb_pixel_coord_streamer.sv
// Bench for pixel_coord_streamer: 4x3 frame via vector table plus scoreboard, and a 1x1 instance.
module tb_pixel_coord_streamer;

  localparam int HA = 4;
  localparam int VA = 3;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [10:0] h_dat;
  logic        h_vld;
  logic        h_rdy;
  logic [9:0]  v_dat;
  logic        v_vld;
  logic        v_rdy;
  logic        eol, eof, busy, frame_done;

  logic        st1, hr1, vr1;
  logic [10:0] hd1;
  logic [9:0]  vd1;
  logic        hv1, vv1, eol1, eof1, busy1, done1;

  always #5 aclk = ~aclk;

  pixel_coord_streamer #(.H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .hcount_axis_tdata(h_dat), .hcount_axis_tvalid(h_vld), .hcount_axis_tready(h_rdy),
    .vcount_axis_tdata(v_dat), .vcount_axis_tvalid(v_vld), .vcount_axis_tready(v_rdy),
    .eol(eol), .eof(eof), .busy(busy), .frame_done(frame_done)
  );

  pixel_coord_streamer #(.H_ACTIVE(1), .V_ACTIVE(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .start(st1),
    .hcount_axis_tdata(hd1), .hcount_axis_tvalid(hv1), .hcount_axis_tready(hr1),
    .vcount_axis_tdata(vd1), .vcount_axis_tvalid(vv1), .vcount_axis_tready(vr1),
    .eol(eol1), .eof(eof1), .busy(busy1), .frame_done(done1)
  );

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        eol;
    logic        eof;
  } pair_t;

  pair_t hq[$];
  pair_t vq[$];

  task automatic push_frame();
    pair_t p;
    for (int v = 0; v < VA; v++) begin
      for (int h = 0; h < HA; h++) begin
        p.h   = 11'(h);
        p.v   = 10'(v);
        p.eol = (h == HA - 1);
        p.eof = (h == HA - 1) && (v == VA - 1);
        hq.push_back(p);
        vq.push_back(p);
      end
    end
  endtask

  // Scoreboard monitor on dut: raster order, hold-while-stalled, drop-after-own-handshake.
  logic  tk_h, tk_v, pw_h, pw_v, h_hs, v_hs;
  logic [10:0] ph_dat;
  logic [9:0]  pv_dat;
  pair_t em;

  always @(negedge aclk) begin
    if (!aresetn) begin
      tk_h = 1'b0; tk_v = 1'b0; pw_h = 1'b0; pw_v = 1'b0;
    end else begin
      if (pw_h) begin
        chk("h_hold_vld", 32'(h_vld), 32'd1);
        chk("h_hold_dat", 32'(h_dat), 32'(ph_dat));
      end
      if (pw_v) begin
        chk("v_hold_vld", 32'(v_vld), 32'd1);
        chk("v_hold_dat", 32'(v_dat), 32'(pv_dat));
      end
      if (tk_h) chk("h_drop_after_hs", 32'(h_vld), 32'd0);
      if (tk_v) chk("v_drop_after_hs", 32'(v_vld), 32'd0);
      h_hs = h_vld & h_rdy;
      v_hs = v_vld & v_rdy;
      if (h_hs) begin
        if (hq.size() == 0) chk("h_extra_beat", 32'd1, 32'd0);
        else begin
          em = hq.pop_front();
          chk("h_beat_dat", 32'(h_dat), 32'(em.h));
          chk("h_beat_eol", 32'(eol), 32'(em.eol));
          chk("h_beat_eof", 32'(eof), 32'(em.eof));
        end
      end
      if (v_hs) begin
        if (vq.size() == 0) chk("v_extra_beat", 32'd1, 32'd0);
        else begin
          em = vq.pop_front();
          chk("v_beat_dat", 32'(v_dat), 32'(em.v));
          chk("v_beat_eol", 32'(eol), 32'(em.eol));
          chk("v_beat_eof", 32'(eof), 32'(em.eof));
        end
      end
      if (frame_done) done_seen++;
      if ((h_hs | tk_h) & (v_hs | tk_v)) begin
        tk_h = 1'b0; tk_v = 1'b0;
      end else begin
        tk_h = tk_h | h_hs;
        tk_v = tk_v | v_hs;
      end
      pw_h = h_vld & ~h_rdy; ph_dat = h_dat;
      pw_v = v_vld & ~v_rdy; pv_dat = v_dat;
    end
  end

  typedef struct {
    logic        st, hr, vr;
    logic        hv, vv;
    logic [10:0] hd;
    logic [9:0]  vd;
    logic        eol, eof, busy, done;
  } vec_t;

  vec_t tbl[16];

  task automatic wait_done(input int target, input int bound, input logic rnd, input logic skew);
    int n;
    n = 0;
    while (done_seen < target && n < bound) begin
      @(posedge aclk); #1;
      if (rnd) begin
        h_rdy = 1'($urandom_range(0, 1));
        v_rdy = 1'($urandom_range(0, 1));
      end else if (skew) begin
        h_rdy = 1'b1;
        v_rdy = (n % 3 == 2);
      end
      @(negedge aclk); #1;
      n++;
    end
    chk("frame_done_count", 32'(done_seen), 32'(target));
    chk("h_queue_drained", 32'(hq.size()), 32'd0);
    chk("v_queue_drained", 32'(vq.size()), 32'd0);
  endtask

  task automatic pulse_start();
    @(posedge aclk); #1;
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    aresetn = 1'b0; start = 1'b0; h_rdy = 1'b1; v_rdy = 1'b1;
    st1 = 1'b0; hr1 = 1'b0; vr1 = 1'b0;

    tbl[0] = '{st:1, hr:1, vr:1, hv:0, vv:0, hd:0, vd:0, eol:0, eof:0, busy:0, done:0};
    for (int i = 1; i <= 12; i++) begin
      tbl[i].st = 0; tbl[i].hr = 1; tbl[i].vr = 1; tbl[i].hv = 1; tbl[i].vv = 1;
      tbl[i].hd = 11'((i - 1) % HA);
      tbl[i].vd = 10'((i - 1) / HA);
      tbl[i].eol = ((i - 1) % HA == HA - 1);
      tbl[i].eof = (i == 12);
      tbl[i].busy = 1; tbl[i].done = 0;
    end
    tbl[13] = '{st:1, hr:1, vr:1, hv:0, vv:0, hd:0, vd:0, eol:0, eof:0, busy:0, done:1};
    tbl[14] = '{st:1, hr:1, vr:1, hv:1, vv:1, hd:0, vd:0, eol:0, eof:0, busy:1, done:0};
    tbl[15] = '{st:0, hr:1, vr:1, hv:1, vv:1, hd:1, vd:0, eol:0, eof:0, busy:1, done:0};

    #3;
    chk("rst_h_vld", 32'(h_vld), 32'd0);
    chk("rst_v_vld", 32'(v_vld), 32'd0);
    chk("rst_h_dat", 32'(h_dat), 32'd0);
    chk("rst_v_dat", 32'(v_dat), 32'd0);
    chk("rst_flags", 32'({eol, eof, busy, frame_done}), 32'd0);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Two frames: the table's first start and the start on the frame_done cycle.
    push_frame();
    push_frame();
    for (int i = 0; i < 16; i++) begin
      @(posedge aclk); #1;
      start = tbl[i].st; h_rdy = tbl[i].hr; v_rdy = tbl[i].vr;
      @(negedge aclk);
      chk($sformatf("tbl%0d_h_vld", i), 32'(h_vld), 32'(tbl[i].hv));
      chk($sformatf("tbl%0d_v_vld", i), 32'(v_vld), 32'(tbl[i].vv));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(frame_done), 32'(tbl[i].done));
      if (tbl[i].hv) begin
        chk($sformatf("tbl%0d_h_dat", i), 32'(h_dat), 32'(tbl[i].hd));
        chk($sformatf("tbl%0d_v_dat", i), 32'(v_dat), 32'(tbl[i].vd));
        chk($sformatf("tbl%0d_eol", i), 32'(eol), 32'(tbl[i].eol));
        chk($sformatf("tbl%0d_eof", i), 32'(eof), 32'(tbl[i].eof));
      end
    end
    @(posedge aclk); #1;
    start = 1'b0;
    wait_done(2, 100, 1'b0, 1'b0);
    @(posedge aclk); #1;
    chk("busy_after_frame", 32'(busy), 32'd0);

    // Skewed acceptance: vcount ready only every third cycle.
    push_frame();
    h_rdy = 1'b1; v_rdy = 1'b0;
    pulse_start();
    wait_done(3, 300, 1'b0, 1'b1);

    // Random independent backpressure over several frames.
    for (int f = 0; f < 3; f++) begin
      push_frame();
      h_rdy = 1'b0; v_rdy = 1'b0;
      pulse_start();
      wait_done(4 + f, 2000, 1'b1, 1'b0);
    end

    // Reset while pair (2,1) is current.
    push_frame();
    h_rdy = 1'b1; v_rdy = 1'b1;
    pulse_start();
    n = 0;
    while (!(h_vld && h_dat == 11'd2 && v_dat == 10'd1) && n < 50) begin
      @(posedge aclk); #1;
      @(negedge aclk); #1;
      n++;
    end
    chk("reached_pair_2_1", 32'(n < 50), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("abort_h_vld", 32'(h_vld), 32'd0);
    chk("abort_v_vld", 32'(v_vld), 32'd0);
    chk("abort_h_dat", 32'(h_dat), 32'd0);
    chk("abort_v_dat", 32'(v_dat), 32'd0);
    chk("abort_flags", 32'({eol, eof, busy, frame_done}), 32'd0);
    hq.delete();
    vq.delete();
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      chk("post_rst_idle", 32'({h_vld, v_vld, busy, frame_done}), 32'd0);
    end
    chk("abort_no_done", 32'(done_seen), 32'd6);

    // 1x1 frame with staggered acceptance.
    @(posedge aclk); #1; st1 = 1'b1;
    @(posedge aclk); #1; st1 = 1'b0;
    @(negedge aclk);
    chk("d1_vld", 32'({hv1, vv1}), 32'b11);
    chk("d1_dat", 32'({hd1, vd1}), 32'd0);
    chk("d1_eol_eof_busy", 32'({eol1, eof1, busy1}), 32'b111);
    @(posedge aclk); #1; hr1 = 1'b1;
    @(posedge aclk); #1; hr1 = 1'b0;
    @(negedge aclk);
    chk("d1_h_taken", 32'({hv1, vv1, busy1, done1}), 32'b0110);
    @(posedge aclk); #1; vr1 = 1'b1;
    @(posedge aclk); #1; vr1 = 1'b0;
    @(negedge aclk);
    chk("d1_done", 32'({hv1, vv1, busy1, done1}), 32'b0001);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("d1_done_one_cycle", 32'(done1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_coord_streamer.md
Name: pixel_coord_streamer

Overview:
Transmitter that walks the active frame raster and sends one (hcount, vcount) coordinate pair per pixel on two AXI-Stream master channels. These channels feed the ray generator's hcount/vcount slave inputs. The block starts a frame on a start pulse and walks row-major (h fastest). It reports line and frame boundaries so downstream pipelines can frame their output.

Parameters:
H_ACTIVE, 640, pixels per line; legal range 1..2048.
V_ACTIVE, 360, lines per frame; legal range 1..1024.

Ports:
aclk  in  1  clock.
aresetn  in  1  asynchronous active-low reset.
start  in  1  single-cycle frame start request.
hcount_axis_tdata  out  11  horizontal coordinate, 0..H_ACTIVE-1.
hcount_axis_tvalid  out  1  hcount beat valid.
hcount_axis_tready  in  1  consumer accepts hcount beat.
vcount_axis_tdata  out  10  vertical coordinate, 0..V_ACTIVE-1.
vcount_axis_tvalid  out  1  vcount beat valid.
vcount_axis_tready  in  1  consumer accepts vcount beat.
eol  out  1  current pair is the last pixel of its line.
eof  out  1  current pair is the last pixel of the frame.
busy  out  1  frame in progress.
frame_done  out  1  one-cycle pulse after the final pair is fully accepted.

Behaviour:
- Clock, reset and polarity: one clock, aclk. Reset is asynchronous and active-low on aresetn. Assertion takes effect immediately, mid-frame included.
- Reset values: all tdata 0, both tvalid 0, eol/eof/busy/frame_done 0. The FSM goes to IDLE and both taken flags clear. The first action after deassertion requires a new start.
- FSM states: IDLE and RUN.
- IDLE -> RUN: on start=1 at edge N, set coordinate to (0,0), raise both tvalid and busy at N+1. Latency start->first valid is 1 cycle.
- RUN, start: ignored.
- Current pair and taken flags:
  - Each channel holds the same current pair.
  - A channel's tvalid stays high until its own handshake (tvalid&tready), then drops and sets that channel's taken flag.
  - tdata is stable while tvalid=1.
- Pair completion: the pair is complete when both channels have handshaked. This can be in the same cycle or in different cycles, in either order.
- Advance on completion, registered at the same edge with no bubble:
  - h<H_ACTIVE-1: h+1.
  - Otherwise: h=0, v+1.
  - Both tvalid re-assert for the new pair and the taken flags clear.
  - At full throughput (both tready held 1), one pair is accepted per cycle.
- Flags: eol=(h==H_ACTIVE-1); eof=eol&(v==V_ACTIVE-1). Both are combinational from the registered counters and qualified by busy.
- Final pair completes at edge M:
  - Go to IDLE; drop both tvalid and busy at M+1.
  - Pulse frame_done high for exactly cycle M+1.
  - A start sampled in cycle M+1 begins a new frame, with valid at M+2.
- Degenerate sizes:
  - H_ACTIVE=1: eol is asserted on every pair.
  - H_ACTIVE=V_ACTIVE=1: one pair (0,0) with eol=eof=1.
- Coordinates zero-extend into the fixed 11/10-bit fields. No counter exceeds its ACTIVE-1 bound.
- Backpressure of any length on either channel must not skip or duplicate any pair.
- Reset during RUN: abort. Partial acceptance is discarded and no frame_done is generated.

Optional Feature:
- Macro: PIXEL_COORD_STREAMER_CONTINUOUS_EN.
- Defined:
  - Final-pair completion wraps to (0,0) and stays in RUN; tvalid stays high with no bubble.
  - frame_done still pulses for one cycle per frame boundary.
  - busy remains 1.
  - start in IDLE still begins streaming.
- Undefined: single-frame behaviour as above.

Test Plan:
- Basic frame, H_ACTIVE=4, V_ACTIVE=3, both tready=1, start pulse:
  - 12 pairs (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2) on consecutive cycles, first one cycle after start.
  - eol on h=3 pairs; eof only on (3,2).
  - frame_done 1 cycle after (3,2) is accepted; busy low after.
- Skewed acceptance:
  - hcount_tready=1 constant, vcount_tready high only every 3rd cycle.
  - hcount_tvalid drops after its handshake and waits.
  - Each pair advances only after the vcount handshake.
  - Sequence is identical to the basic frame with no duplicates.
- Random independent backpressure (50% per channel), 640x360: exactly 230400 pairs in raster order on each channel, one frame_done.
- Start while busy, mid-frame: ignored, no counter reset. Start on the frame_done cycle: new frame begins at (0,0) next cycle.
- Reset mid-frame: assert aresetn=0 at pair (2,1). All outputs go to 0 immediately and no frame_done is generated. After release with no start, tvalid stays 0 for 20 cycles.
- With PIXEL_COORD_STREAMER_CONTINUOUS_EN, 2x2, tready=1: the sequence (0,0),(1,0),(0,1),(1,1),(0,0)... is gapless, with frame_done on every 4th-pair boundary.
